seg_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands one SEG-bit segment per clock.
- The carry is held in a register between segments.
- Successor to the 4-bit combinational ripple-carry adder. Adds configurable width, subtract mode, signed-overflow flag and a start/busy/done handshake.
- Intended as the area-lean arithmetic unit behind sequential datapaths in the design.

---
 rtl/seg_adder_pkg.sv | 19 +
 rtl/seg_adder_slice.sv | 28 ++
 rtl/seg_adder.sv | 117 +++++++++++
 tb/tb_seg_adder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_adder_pkg.sv
// Shared types and sizing helpers for the segmented adder/subtractor.
package seg_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int calc_nseg(input int width, input int seg);
    return width / seg;
  endfunction

  // A single-segment adder still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nseg);
    return (nseg > 1) ? $clog2(nseg) : 1;
  endfunction

endpackage

// File: rtl/seg_adder_slice.sv
// Combinational SEG-bit ripple adder; also exposes the carry into its MSB
// so the top level can derive signed overflow.
module seg_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  always_comb begin
    logic carry;
    // NOTE: every output gets a default first so no path can infer a latch.
    s     = '0;
    c_msb = 1'b0;
    carry = ci;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) c_msb = carry;
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/seg_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one SEG-bit segment per clock,
// carry held in a register between segments, start/busy/done handshake.
module seg_adder
  import seg_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSEG  = calc_nseg(WIDTH, SEG);
  localparam int IDX_W = calc_idx_w(NSEG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_nxt;
  logic [WIDTH-1:0] a_shift, b_shift;
  logic             carry_q;
  logic [IDX_W-1:0] seg_idx;
  logic [SEG-1:0]   slice_s;
  logic             slice_co, slice_c_msb;
  logic             last_seg;
  int               seg_base;

  // Single shared slice; the current segment is selected by shifting.
  assign seg_base = int'(seg_idx) * SEG;
  assign a_shift  = a_q >> seg_base;
  assign b_shift  = b_q >> seg_base;
  assign last_seg = (seg_idx == LAST_IDX);

  seg_slice #(.SEG(SEG)) u_slice (
    .x     (a_shift[SEG-1:0]),
    .y     (b_shift[SEG-1:0]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_c_msb)
  );

  always_comb begin
    work_nxt                    = work_q;
    work_nxt[seg_base +: SEG]   = slice_s;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_seg) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      seg_idx <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          // Subtraction is a + ~b + 1: invert b here, inject the 1 as carry.
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= sub | c_in;
          seg_idx <= '0;
          work_q  <= '0;
        end
        ST_RUN: begin
          work_q  <= work_nxt;
          carry_q <= slice_co;
          seg_idx <= seg_idx + 1'b1;
          if (last_seg) begin
            sum   <= work_nxt;
            c_out <= slice_co;
            ovf   <= slice_c_msb ^ slice_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_adder.sv
// Self-checking bench for seg_adder: directed vectors, handshake corner
// cases, and randomized sweeps on 16/4, 8/8 and 32/8 instances.
module tb_seg_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    longint unsigned sum;
    bit              cout;
    bit              ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in, b_in;
  logic        cin_in, sub_in;
  logic [2:0]  start_v;
  logic [15:0] sum16;
  logic [7:0]  sum8;
  logic [31:0] sum32;
  logic [2:0]  busy_v, done_v, cout_v, ovf_v;
  logic [63:0] sum_v [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign sum_v[0] = 64'(sum16);
  assign sum_v[1] = 64'(sum8);
  assign sum_v[2] = 64'(sum32);

  seg_adder #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in[15:0]), .b(b_in[15:0]),
    .c_in(cin_in), .sub(sub_in), .busy(busy_v[0]), .done(done_v[0]),
    .sum(sum16), .c_out(cout_v[0]), .ovf(ovf_v[0]));

  seg_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in[7:0]), .b(b_in[7:0]),
    .c_in(cin_in), .sub(sub_in), .busy(busy_v[1]), .done(done_v[1]),
    .sum(sum8), .c_out(cout_v[1]), .ovf(ovf_v[1]));

  seg_adder #(.WIDTH(32), .SEG(8)) dut32 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in), .b(b_in),
    .c_in(cin_in), .sub(sub_in), .busy(busy_v[2]), .done(done_v[2]),
    .sum(sum32), .c_out(cout_v[2]), .ovf(ovf_v[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Modular and signed arithmetic straight from the operation's definition.
  function automatic res_t ref_model(input int w, input longint unsigned a,
                                     input longint unsigned b, input bit cin, input bit sub);
    res_t            r;
    longint unsigned m    = (64'd1 << w) - 1;
    longint          lim  = longint'(64'd1 << (w - 1));
    longint          c    = cin ? 1 : 0;
    longint unsigned full;
    longint          sa, sb, sr;
    sa = (a >= lim) ? longint'(a) - 2 * lim : longint'(a);
    sb = (b >= lim) ? longint'(b) - 2 * lim : longint'(b);
    if (sub) begin
      full = a + (~b & m) + 1;
      sr   = sa - sb;
    end else begin
      full = a + b + longint'(c);
      sr   = sa + sb + c;
    end
    r.sum  = full & m;
    r.cout = full[w];
    r.ovf  = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  // Issue one operation on instance sel, check latency and busy width,
  // and return the outputs seen in the done cycle.
  task automatic run_op(input int sel, input int lat_exp, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic sub,
                        input string tag, output logic [63:0] s,
                        output logic co, output logic ov);
    int lat;
    int bcnt;
    @(negedge clk);
    a_in = a; b_in = b; cin_in = cin; sub_in = sub;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    bcnt = int'(busy_v[sel]);
    @(negedge clk);
    start_v[sel] = 1'b0;
    a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom); sub_in = 1'($urandom);
    lat = 1;
    while (lat <= 40) begin
      @(posedge clk); #1;
      if (done_v[sel]) break;
      bcnt += int'(busy_v[sel]);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(lat_exp));
    check({tag, " busy cycles"}, 64'(bcnt), 64'(lat_exp));
    check({tag, " busy at done"}, 64'(busy_v[sel]), 64'd0);
    s  = sum_v[sel];
    co = cout_v[sel];
    ov = ovf_v[sel];
    @(posedge clk); #1;
    check({tag, " done single pulse"}, 64'(done_v[sel]), 64'd0);
  endtask

  task automatic random_sweep(input int sel, input int w, input int seg, input int n_ops);
    logic [63:0]     s;
    logic            co, ov;
    logic [31:0]     m;
    longint unsigned ra, rb;
    bit              rc, rs;
    res_t            r;
    m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 1;
    for (int i = 0; i < n_ops; i++) begin
      ra = longint'($urandom & m);
      rb = longint'($urandom & m);
      rc = 1'($urandom);
      rs = 1'($urandom);
      r  = ref_model(w, ra, rb, rc, rs);
      run_op(sel, w / seg, 32'(ra), 32'(rb), rc, rs, $sformatf("rand w%0d #%0d", w, i), s, co, ov);
      check($sformatf("rand w%0d #%0d sum", w, i), s, r.sum);
      check($sformatf("rand w%0d #%0d c_out", w, i), 64'(co), 64'(r.cout));
      check($sformatf("rand w%0d #%0d ovf", w, i), 64'(ov), 64'(r.ovf));
    end
  endtask

  initial begin
    vec_t        vecs [7];
    logic [63:0] s;
    logic        co, ov;
    int          cnt;

    vecs[0] = '{16'h0006, 16'h000C, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[6] = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start_v = '0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset busy[%0d]", i), 64'(busy_v[i]), 64'd0);
      check($sformatf("reset done[%0d]", i), 64'(done_v[i]), 64'd0);
      check($sformatf("reset sum[%0d]", i), sum_v[i], 64'd0);
      check($sformatf("reset c_out[%0d]", i), 64'(cout_v[i]), 64'd0);
      check($sformatf("reset ovf[%0d]", i), 64'(ovf_v[i]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(0, 4, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, vecs[i].sub,
             $sformatf("vec%0d", i), s, co, ov);
      check($sformatf("vec%0d sum", i), s, 64'(vecs[i].sum));
      check($sformatf("vec%0d c_out", i), 64'(co), 64'(vecs[i].cout));
      check($sformatf("vec%0d ovf", i), 64'(ov), 64'(vecs[i].ovf));
    end

    // start re-pulsed during RUN and during DONE must be ignored
    @(negedge clk);
    a_in = 32'h1111; b_in = 32'h2222; cin_in = 1'b0; sub_in = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b1; a_in = 32'hFFFF;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk); #1;
      if (done_v[0]) break;
      cnt++;
    end
    check("ignore: done seen", 64'(done_v[0]), 64'd1);
    check("ignore: sum", sum_v[0], 64'h3333);
    @(negedge clk); start_v[0] = 1'b1; a_in = 32'hFFFF;
    @(posedge clk); #1;
    check("ignore: done after DONE", 64'(done_v[0]), 64'd0);
    check("ignore: busy after DONE", 64'(busy_v[0]), 64'd0);
    @(negedge clk); start_v[0] = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      cnt += int'(done_v[0]) + int'(busy_v[0]);
    end
    check("ignore: no second op", 64'(cnt), 64'd0);
    check("ignore: sum held", sum_v[0], 64'h3333);

    // asynchronous reset in the middle of an operation
    run_op(0, 4, 32'h0006, 32'h000C, 1'b0, 1'b0, "pre-reset", s, co, ov);
    check("pre-reset sum", s, 64'h0012);
    @(negedge clk);
    a_in = 32'h00F0; b_in = 32'h0F00; cin_in = 1'b0; sub_in = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("mid-op busy before reset", 64'(busy_v[0]), 64'd1);
    rst = 1'b1;
    #1;
    check("async reset busy", 64'(busy_v[0]), 64'd0);
    check("async reset done", 64'(done_v[0]), 64'd0);
    check("async reset sum", sum_v[0], 64'd0);
    check("async reset c_out", 64'(cout_v[0]), 64'd0);
    check("async reset ovf", 64'(ovf_v[0]), 64'd0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      cnt += int'(done_v[0]);
    end
    check("no done after reset", 64'(cnt), 64'd0);
    run_op(0, 4, 32'h00F0, 32'h0F00, 1'b0, 1'b0, "post-reset", s, co, ov);
    check("post-reset sum", s, 64'h0FF0);
    check("post-reset c_out", 64'(co), 64'd0);

    random_sweep(0, 16, 4, 200);
    random_sweep(1, 8, 8, 1000);
    random_sweep(2, 32, 8, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
